// File: rtl/user_mem_responder_pkg.sv
// mem_resp_pkg: shared types, sizing constants and result address mapping for the memory responder
package mem_resp_pkg;
  typedef enum logic [1:0] {TEMPLATE, WINDOW, RESULT} region_e;
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_e;
  localparam int NUM_SETS = 150;
  localparam int WORDS_PER_SET = 3;
  localparam int RESULT_DEPTH = 512;
  function automatic logic [8:0] res_addr(input logic [7:0] s, input logic [1:0] i, input int wps);
    return 9'(int'(s) * wps + int'(i));
  endfunction
endpackage

// File: rtl/user_mem_responder_if.sv
// user_mem_responder_if: user request bus and host access bus of the memory responder
interface user_mem_responder_if #(
  parameter int ROW_W = 7,
  parameter int COL_W = 7,
  parameter int DATA_W = 32
);
  logic req, rd_wr, tem_win, set_done;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [7:0] set;
  logic [1:0] wr_index;
  logic [DATA_W-1:0] write_data, read_data;
  logic ready_2_start;
  logic host_req, host_we, host_start, host_ready, host_rvalid, frame_irq, err;
  logic [1:0] host_sel;
  logic [13:0] host_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata;
  modport master (
    output req, rd_wr, tem_win, row, col, set, wr_index, write_data, set_done,
    output host_req, host_we, host_sel, host_addr, host_wdata, host_start,
    input read_data, ready_2_start, host_ready, host_rdata, host_rvalid, frame_irq, err
  );
  modport slave (
    input req, rd_wr, tem_win, row, col, set, wr_index, write_data, set_done,
    input host_req, host_we, host_sel, host_addr, host_wdata, host_start,
    output read_data, ready_2_start, host_ready, host_rdata, host_rvalid, frame_irq, err
  );
endinterface

// File: rtl/user_mem_responder_sp_ram.sv
// sp_ram: single-port RAM, synchronous read, write-first
module sp_ram #(
  parameter int DEPTH = 512,
  parameter int AW = $clog2(DEPTH),
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_q <= we_i ? wdata_i : mem_q[addr_i];
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/user_mem_responder.sv
// user_mem_responder: template/window/result RAMs shared by the user datapath and the host, with frame FSM
module user_mem_responder #(
  parameter int ROW_W = 7,
  parameter int COL_W = 7,
  parameter int DATA_W = 32,
  parameter int NUM_SETS = mem_resp_pkg::NUM_SETS,
  parameter int WORDS_PER_SET = mem_resp_pkg::WORDS_PER_SET
) (
  input logic clk,
  input logic rst_n,
  user_mem_responder_if.slave bus
);
  import mem_resp_pkg::*;
  localparam int AW = ROW_W + COL_W;
  localparam int RW = $clog2(RESULT_DEPTH);
  state_e state_q, state_d;
  logic served, usr_rd, usr_wr, wr_ok, host_acc, h_we, err_q, err_d, frame_irq_q;
  logic t_en, w_en, r_en, r_we;
  logic [AW-1:0] rd_addr;
  logic [RW-1:0] r_addr;
  logic [DATA_W-1:0] t_rdata, w_rdata, r_rdata, r_wdata, hr_mux, rd_hold_q, hr_hold_q;
  logic rd_pend_q, rd_win_q, hr_valid_q;
  logic [1:0] hr_sel_q;
  assign bus.host_ready = state_q != RUN && !bus.req;
  assign served = bus.req && state_q != IDLE;
  assign usr_rd = served && !bus.rd_wr;
  assign usr_wr = served && bus.rd_wr;
  assign wr_ok = usr_wr && int'(bus.set) < NUM_SETS && bus.wr_index != 2'd3;
  assign host_acc = bus.host_req && bus.host_ready;
  assign h_we = host_acc && bus.host_we;
  // host_acc implies !req, so req alone steers every RAM port to the user side
  assign rd_addr = bus.req ? {bus.row, bus.col} : bus.host_addr[AW-1:0];
  assign r_addr = bus.req ? res_addr(bus.set, bus.wr_index, WORDS_PER_SET) : bus.host_addr[RW-1:0];
  assign r_wdata = bus.req ? bus.write_data : bus.host_wdata;
  assign t_en = (usr_rd && !bus.tem_win) || (host_acc && bus.host_sel == TEMPLATE);
  assign w_en = (usr_rd && bus.tem_win) || (host_acc && bus.host_sel == WINDOW);
  assign r_en = wr_ok || (host_acc && bus.host_sel == RESULT);
  assign r_we = wr_ok || h_we;
  sp_ram #(.DEPTH(1 << AW), .AW(AW), .DW(DATA_W)) u_tmpl (
    .clk(clk), .en_i(t_en), .we_i(h_we), .addr_i(rd_addr), .wdata_i(bus.host_wdata), .rdata_o(t_rdata)
  );
  sp_ram #(.DEPTH(1 << AW), .AW(AW), .DW(DATA_W)) u_win (
    .clk(clk), .en_i(w_en), .we_i(h_we), .addr_i(rd_addr), .wdata_i(bus.host_wdata), .rdata_o(w_rdata)
  );
  sp_ram #(.DEPTH(RESULT_DEPTH), .AW(RW), .DW(DATA_W)) u_res (
    .clk(clk), .en_i(r_en), .we_i(r_we), .addr_i(r_addr), .wdata_i(r_wdata), .rdata_o(r_rdata)
  );
  always_comb begin
    state_d = state_q == IDLE  ? (bus.host_start ? ARMED : IDLE) :
              state_q == ARMED ? (bus.req ? RUN : ARMED) :
                                 (bus.set_done ? IDLE : RUN);
    err_d = (err_q && !(state_q == IDLE && bus.host_start)) ||
            (bus.req && state_q == IDLE) || (usr_wr && !wr_ok);
  end
  // RAM outputs can be disturbed by later accesses, so each reader keeps its own hold copy
  assign bus.read_data = rd_pend_q ? (rd_win_q ? w_rdata : t_rdata) : rd_hold_q;
  assign hr_mux = hr_sel_q == TEMPLATE ? t_rdata :
                  hr_sel_q == WINDOW   ? w_rdata :
                  hr_sel_q == RESULT   ? r_rdata : '0;
  assign bus.host_rdata = hr_valid_q ? hr_mux : hr_hold_q;
  assign bus.host_rvalid = hr_valid_q;
  assign bus.ready_2_start = state_q == ARMED;
  assign bus.frame_irq = frame_irq_q;
  assign bus.err = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q <= 1'b0;
      frame_irq_q <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_win_q <= 1'b0;
      rd_hold_q <= '0;
      hr_valid_q <= 1'b0;
      hr_sel_q <= 2'd0;
      hr_hold_q <= '0;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
      frame_irq_q <= state_q == RUN && bus.set_done;
      rd_pend_q <= usr_rd;
      if (usr_rd) rd_win_q <= bus.tem_win;
      if (rd_pend_q) rd_hold_q <= bus.read_data;
      hr_valid_q <= host_acc && !bus.host_we;
      if (host_acc) hr_sel_q <= bus.host_sel;
      if (hr_valid_q) hr_hold_q <= hr_mux;
    end
  end
endmodule

// File: tb/tb_user_mem_responder.sv
// tb_user_mem_responder: directed self-checking bench for the memory responder
module tb_user_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rd;
  logic rv;
  always #5 clk = ~clk;
  user_mem_responder_if bus ();
  user_mem_responder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic host_xfer(input logic we, input logic [1:0] sel, input logic [13:0] addr,
                           input logic [31:0] wd, output logic [31:0] rdat, output logic rval);
    int n = 0;
    bus.host_req = 1'b1;
    bus.host_we = we;
    bus.host_sel = sel;
    bus.host_addr = addr;
    bus.host_wdata = wd;
    #1;
    while (!bus.host_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.host_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL host_timeout: host_ready=%b required 1", bus.host_ready);
    end
    @(negedge clk);
    bus.host_req = 1'b0;
    bus.host_we = 1'b0;
    rdat = bus.host_rdata;
    rval = bus.host_rvalid;
  endtask

  task automatic user_op(input logic wr, input logic tw, input logic [6:0] r, input logic [6:0] c,
                         input logic [7:0] s, input logic [1:0] idx, input logic [31:0] d);
    bus.req = 1'b1;
    bus.rd_wr = wr;
    bus.tem_win = tw;
    bus.row = r;
    bus.col = c;
    bus.set = s;
    bus.wr_index = idx;
    bus.write_data = d;
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic pulse_start();
    bus.host_start = 1'b1;
    @(negedge clk);
    bus.host_start = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.read_data !== 32'h0) begin n_bad++; $display("FAIL rst_read_data: got %h want 0", bus.read_data); end
    n_cmp++; if (bus.host_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_host_rdata: got %h want 0", bus.host_rdata); end
    n_cmp++; if ({bus.ready_2_start, bus.host_rvalid, bus.frame_irq, bus.err} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_flags: got %b want 0000", {bus.ready_2_start, bus.host_rvalid, bus.frame_irq, bus.err});
    end
    n_cmp++; if (bus.host_ready !== 1'b1) begin n_bad++; $display("FAIL rst_host_ready: got %b want 1", bus.host_ready); end
  endtask

  task automatic test_template_read();
    host_xfer(1'b1, 2'd0, 14'h105, 32'hDEADBEEF, rd, rv);
    for (int i = 0; i < 16; i++) host_xfer(1'b1, 2'd1, 14'h200 + 14'(i), 32'hA5A50000 + 32'(i), rd, rv);
    host_xfer(1'b1, 2'd2, 14'd450, 32'h00000055, rd, rv);
    pulse_start();
    n_cmp++; if (bus.ready_2_start !== 1'b1) begin n_bad++; $display("FAIL armed_ready: got %b want 1", bus.ready_2_start); end
    n_cmp++; if (bus.host_ready !== 1'b1) begin n_bad++; $display("FAIL armed_host_ready: got %b want 1", bus.host_ready); end
    user_op(1'b0, 1'b0, 7'd2, 7'd5, 8'd0, 2'd0, 32'h0);
    n_cmp++; if (bus.read_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL tmpl_read: got %h want deadbeef", bus.read_data); end
    n_cmp++; if (bus.ready_2_start !== 1'b0) begin n_bad++; $display("FAIL run_ready: got %b want 0", bus.ready_2_start); end
    n_cmp++; if (bus.host_ready !== 1'b0) begin n_bad++; $display("FAIL run_host_ready: got %b want 0", bus.host_ready); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      bus.req = 1'b1;
      bus.rd_wr = 1'b0;
      bus.tem_win = 1'b1;
      bus.row = 7'd4;
      bus.col = 7'(i);
      @(negedge clk);
      n_cmp++; if (bus.read_data !== 32'hA5A50000 + 32'(i)) begin
        n_bad++; $display("FAIL b2b_read[%0d]: got %h want %h", i, bus.read_data, 32'hA5A50000 + 32'(i));
      end
    end
    bus.req = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.read_data !== 32'hA5A5000F) begin n_bad++; $display("FAIL b2b_hold: got %h want a5a5000f", bus.read_data); end
  endtask

  task automatic test_result_write();
    user_op(1'b1, 1'b0, 7'd0, 7'd0, 8'd149, 2'd2, 32'h12345678);
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL good_write_err: got %b want 0", bus.err); end
    user_op(1'b1, 1'b0, 7'd0, 7'd0, 8'd150, 2'd0, 32'hBAD0BAD0);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL bad_set_err: got %b want 1", bus.err); end
  endtask

  task automatic test_host_blocked();
    bus.host_req = 1'b1;
    bus.host_we = 1'b0;
    bus.host_sel = 2'd2;
    bus.host_addr = 14'd449;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.host_ready !== 1'b0) begin n_bad++; $display("FAIL blocked_ready[%0d]: got %b want 0", i, bus.host_ready); end
      @(negedge clk);
    end
    bus.set_done = 1'b1;
    @(negedge clk);
    bus.set_done = 1'b0;
    n_cmp++; if (bus.frame_irq !== 1'b1) begin n_bad++; $display("FAIL irq_pulse: got %b want 1", bus.frame_irq); end
    n_cmp++; if (bus.host_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b want 1", bus.host_ready); end
    @(negedge clk);
    bus.host_req = 1'b0;
    n_cmp++; if (bus.host_rvalid !== 1'b1) begin n_bad++; $display("FAIL res_rvalid: got %b want 1", bus.host_rvalid); end
    n_cmp++; if (bus.host_rdata !== 32'h12345678) begin n_bad++; $display("FAIL res_449: got %h want 12345678", bus.host_rdata); end
    n_cmp++; if (bus.frame_irq !== 1'b0) begin n_bad++; $display("FAIL irq_once: got %b want 0", bus.frame_irq); end
    @(negedge clk);
    n_cmp++; if (bus.host_rvalid !== 1'b0) begin n_bad++; $display("FAIL rvalid_pulse: got %b want 0", bus.host_rvalid); end
    n_cmp++; if (bus.host_rdata !== 32'h12345678) begin n_bad++; $display("FAIL rdata_hold: got %h want 12345678", bus.host_rdata); end
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", bus.err); end
    host_xfer(1'b0, 2'd2, 14'd450, 32'h0, rd, rv);
    n_cmp++; if ({rv, rd} !== {1'b1, 32'h00000055}) begin n_bad++; $display("FAIL res_450_unchanged: got %b/%h want 1/00000055", rv, rd); end
  endtask

  task automatic test_region3_and_err_clear();
    host_xfer(1'b1, 2'd3, 14'd0, 32'hFFFFFFFF, rd, rv);
    host_xfer(1'b0, 2'd3, 14'd0, 32'h0, rd, rv);
    n_cmp++; if ({rv, rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL region3_read: got %b/%h want 1/00000000", rv, rd); end
    pulse_start();
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", bus.err); end
    n_cmp++; if (bus.ready_2_start !== 1'b1) begin n_bad++; $display("FAIL rearm: got %b want 1", bus.ready_2_start); end
  endtask

  task automatic test_reset_mid_run();
    user_op(1'b0, 1'b0, 7'd2, 7'd5, 8'd0, 2'd0, 32'h0);
    n_cmp++; if (bus.ready_2_start !== 1'b0) begin n_bad++; $display("FAIL run2_ready: got %b want 0", bus.ready_2_start); end
    rst_n = 1'b0;
    #2;
    n_cmp++; if (bus.read_data !== 32'h0) begin n_bad++; $display("FAIL midrst_read_data: got %h want 0", bus.read_data); end
    n_cmp++; if (bus.host_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_idle: got %b want 1", bus.host_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.ready_2_start !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", bus.ready_2_start); end
    host_xfer(1'b0, 2'd0, 14'h105, 32'h0, rd, rv);
    n_cmp++; if ({rv, rd} !== {1'b1, 32'hDEADBEEF}) begin n_bad++; $display("FAIL tmpl_retained: got %b/%h want 1/deadbeef", rv, rd); end
  endtask

  task automatic test_idle_req();
    user_op(1'b0, 1'b0, 7'd2, 7'd5, 8'd0, 2'd0, 32'h0);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL idle_req_err: got %b want 1", bus.err); end
    n_cmp++; if (bus.read_data !== 32'h0) begin n_bad++; $display("FAIL idle_req_ignored: got %h want 0", bus.read_data); end
  endtask

  initial begin
    {bus.req, bus.rd_wr, bus.tem_win, bus.set_done, bus.host_req, bus.host_we, bus.host_start} = '0;
    bus.row = '0;
    bus.col = '0;
    bus.set = '0;
    bus.wr_index = '0;
    bus.write_data = '0;
    bus.host_sel = '0;
    bus.host_addr = '0;
    bus.host_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_template_read();
    test_back_to_back();
    test_result_write();
    test_host_blocked();
    test_region3_and_err_clear();
    test_reset_mid_run();
    test_idle_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
